capture_readout_sequencer: RTL

//  Sequences one acquisition of the LogicCapture engine and then streams the captured

---
 rtl/capture_readout_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/capture_readout_sequencer.sv
// capture_readout_sequencer: arms LogicCapture, waits for capture-done, then streams the
// circular pre/post-trigger window out of sample RAM as a valid/ready sample stream.
module capture_readout_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int START_HOLD = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              host_arm,
    input  logic              host_abort,
    input  logic [15:0]       pre_count,
    input  logic [15:0]       post_count,
    output logic              cap_start,
    input  logic              cap_done,
    input  logic [ADDR_W-1:0] cap_trig_addr,
    output logic              ram_owner,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done_pulse
);
    localparam int CW = (ADDR_W >= 17) ? ADDR_W + 1 : 17;
    localparam int HW = $clog2(START_HOLD + 1);
    localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_W;

    typedef enum logic [2:0] {IDLE, ARM, WAIT, READ, FIN} state_t;

    state_t            state_q, state_d;
    logic [15:0]       pre_q, pre_d, post_q, post_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     issue_left_q, issue_left_d, out_left_q, out_left_d;
    logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic              pop;
    logic [1:0]        occ;
    logic [CW-1:0]     sum, total;

    assign sum         = CW'(pre_q) + CW'(post_q) + CW'(1);
    assign total       = (sum > DEPTH) ? DEPTH : sum;
    assign m_valid     = cnt_q != 2'd0;
    assign m_data      = b0_q;
    assign m_last      = m_valid && out_left_q == CW'(1);
    assign pop         = m_valid && m_ready;
    assign cap_start   = state_q == ARM;
    assign ram_owner   = state_q == READ;
    assign busy        = state_q != IDLE;
    assign done_pulse  = state_q == FIN;
    assign ram_rd_addr = addr_q;
    // Occupancy after this cycle's pop, so a read can be issued into the slot being freed.
    assign occ         = cnt_q - 2'(pop) + 2'(inflight_q);
    assign ram_rd_en   = state_q == READ && issue_left_q != '0 && occ < 2'd2;

    always_comb begin
        state_d      = state_q;
        pre_d        = pre_q;
        post_d       = post_q;
        hold_d       = hold_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        case (state_q)
            IDLE: begin
                if (host_arm && !host_abort) begin
                    pre_d   = pre_count;
                    post_d  = post_count;
                    hold_d  = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                hold_d  = hold_q + HW'(1);
                state_d = (hold_q == HW'(START_HOLD - 1)) ? WAIT : ARM;
            end
            WAIT: begin
                if (cap_done) begin
                    addr_d       = cap_trig_addr - ADDR_W'(pre_q);
                    issue_left_d = total;
                    out_left_d   = total;
                    state_d      = READ;
                end
            end
            READ: begin
                if (ram_rd_en) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - CW'(1);
                end
                if (pop) begin
                    out_left_d = out_left_q - CW'(1);
                    state_d    = (out_left_q == CW'(1)) ? FIN : READ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        b0_d       = pop ? b1_q : b0_q;
        b1_d       = b1_q;
        if (inflight_q) begin
            if (cnt_q - 2'(pop) == 2'd0) b0_d = ram_rd_data;
            else b1_d = ram_rd_data;
        end
        cnt_d      = occ;
        inflight_d = ram_rd_en;
        if (host_abort) begin
            state_d    = IDLE;
            cnt_d      = 2'd0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            post_q       <= '0;
            hold_q       <= '0;
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            cnt_q        <= cnt_d;
            inflight_q   <= inflight_d;
        end
    end
endmodule
